// File: rtl/logic_gate_panel_pkg.sv
// logic_gate_panel_pkg: LED bit positions, default debounce length and the gate map.
package logic_gate_panel_pkg;
   localparam int LED_AND = 0;
   localparam int LED_OR  = 1;
   localparam int LED_XOR = 2;
   localparam int LED_NOR = 3;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
   function automatic logic [3:0] gates(input logic a, input logic b);
      logic [3:0] g;
      g          = '0;
      g[LED_AND] = a & b;
      g[LED_OR]  = a | b;
      g[LED_XOR] = a ^ b;
      g[LED_NOR] = ~(a | b);
      return g;
   endfunction
endpackage

// File: rtl/logic_gate_panel_if.sv
// logic_gate_panel_if: switch pins in, LED pins out.
interface logic_gate_panel_if;
   logic [1:0] switch;
   logic [3:0] led;
   modport master (output switch, input led);
   modport slave  (input switch, output led);
endinterface

// File: rtl/logic_gate_panel_switch_debounce.sv
// switch_debounce: 2-flop synchronizer followed by a level debouncer for one switch bit.
module switch_debounce
   import logic_gate_panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);
   logic s1, s2;
   logic [CNT_W-1:0] cnt;
   // Any cycle where the synchronized level matches the accepted one restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         dout <= 1'b0;
         cnt  <= '0;
      end else begin
         s1 <= din;
         s2 <= s1;
         if (s2 == dout) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            dout <= s2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/logic_gate_panel.sv
// logic_gate_panel: two debounced switches drive four registered LEDs, one 2-input gate each.
module logic_gate_panel
   import logic_gate_panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input logic clk,
   input logic rst_n,
   logic_gate_panel_if.slave bus
);
   logic [1:0] db;
   for (genvar i = 0; i < 2; i++) begin : g_db
      switch_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W(CNT_W)
      ) u_db (
         .clk(clk),
         .rst_n(rst_n),
         .din(bus.switch[i]),
         .dout(db[i])
      );
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.led <= '0;
      else bus.led <= gates(db[0], db[1]);
   end
endmodule

// File: tb/tb_logic_gate_panel.sv
// tb_logic_gate_panel: directed vectors with a cycle-tagged expectation queue and a separate monitor.
module tb_logic_gate_panel;
   typedef struct {
      int         at;
      logic [3:0] led;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   logic_gate_panel_if bus();

   logic_gate_panel #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (bus.led !== e.led || e.at != cyc) begin
            errors++;
            $display("FAIL %s cyc=%0d led=%b want %b (due cyc %0d)", e.name, cyc, bus.led, e.led, e.at);
         end
      end
   end

   task automatic expect_at(input int k, input logic [3:0] v, input string n);
      exp_t e;
      e.at = cyc + k;
      e.led = v;
      e.name = n;
      sb.push_back(e);
   endtask

   task automatic wait_neg(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic apply(input logic [1:0] sw, input logic [3:0] prev, input logic [3:0] want, input string n);
      bus.switch = sw;
      expect_at(6, prev, {n, "_edge6"});
      expect_at(7, want, {n, "_edge7"});
      expect_at(19, want, {n, "_hold"});
      wait_neg(20);
   endtask

   initial begin
      bus.switch = 2'b00;
      @(negedge clk);
      expect_at(1, 4'b0000, "reset_hold1");
      expect_at(2, 4'b0000, "reset_hold2");
      wait_neg(2);
      rst_n = 1'b1;
      expect_at(1, 4'b1000, "reset_release");
      wait_neg(3);

      apply(2'b10, 4'b1000, 4'b0110, "tt_b1a0");
      apply(2'b01, 4'b0110, 4'b0110, "tt_b0a1");
      apply(2'b11, 4'b0110, 4'b0011, "tt_b1a1");
      apply(2'b00, 4'b0011, 4'b1000, "tt_b0a0");
      apply(2'b11, 4'b1000, 4'b0011, "latency_00_11");
      apply(2'b00, 4'b0011, 4'b1000, "latency_11_00");

      bus.switch = 2'b01;
      expect_at(7, 4'b1000, "glitch3_e7");
      expect_at(8, 4'b1000, "glitch3_e8");
      expect_at(12, 4'b1000, "glitch3_e12");
      wait_neg(3);
      bus.switch = 2'b00;
      wait_neg(17);

      bus.switch = 2'b01;
      expect_at(6, 4'b1000, "glitch4_e6");
      expect_at(7, 4'b0110, "glitch4_e7");
      expect_at(10, 4'b0110, "glitch4_e10");
      expect_at(11, 4'b1000, "glitch4_e11");
      wait_neg(4);
      bus.switch = 2'b00;
      wait_neg(16);

      apply(2'b11, 4'b1000, 4'b0011, "pre_reset");
      bus.switch = 2'b00;
      expect_at(3, 4'b0011, "midrst_before");
      expect_at(4, 4'b0000, "midrst_assert");
      expect_at(5, 4'b0000, "midrst_held");
      wait_neg(3);
      #2 rst_n = 1'b0;
      wait_neg(3);
      rst_n = 1'b1;
      expect_at(1, 4'b1000, "midrst_release");
      for (int k = 2; k <= 10; k++) expect_at(k, 4'b1000, "midrst_no_transient");
      wait_neg(12);

      expect_at(6, 4'b1000, "indep_e6");
      expect_at(7, 4'b0110, "indep_e7");
      expect_at(15, 4'b0110, "indep_mid");
      expect_at(23, 4'b0110, "indep_late");
      for (int k = 0; k < 12; k++) begin
         bus.switch = {1'b1, k[0] ? 1'b0 : 1'b1};
         wait_neg(2);
      end
      bus.switch = 2'b10;
      expect_at(10, 4'b0110, "indep_settled");
      wait_neg(12);

      for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain pending=%0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d want completion", cyc);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/logic_gate_panel.md
Name: logic_gate_panel

Overview:
- Board-level demo block: two slide switches drive four LEDs, each LED showing one 2-input logic function of the switches.
- Switch inputs are asynchronous. They pass through a 2-flop synchronizer and a per-bit debouncer before gate evaluation.
- LED outputs are registered.
- Sits directly between the top-level switch pins and the LED pins.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clock cycles a synchronized switch level must differ from the accepted level before it is accepted. Legal range ≥1. Board builds override it (e.g. 1_000_000 at 100 MHz).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width. Derived; not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- switch  input  2  raw slide switches, asynchronous to clk. a = switch[0], b = switch[1].
- led  output  4  registered gate results.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - sync flops s1/s2 = 2'b00
  - debounced value db = 2'b00
  - debounce counters = 0
  - led = 4'b0000 (all dark)
- Release is sampled synchronously. On the first rising edge after release, led becomes gates(00) = 4'b1000.
- Synchronizer: s1 <= switch; s2 <= s1. Bit-wise, no reset-free flops.
- Debounce, per bit i, independent:
  - s2[i] == db[i]: cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - When cnt[i] == DEBOUNCE_CYCLES-1 and s2[i] != db[i]: db[i] <= s2[i]; cnt[i] <= 0.
  - A level returning to db[i] before acceptance clears the count, so glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- Gate map, registered every cycle, with a = db[0], b = db[1]:
  - led[0] = a AND b
  - led[1] = a OR b
  - led[2] = a XOR b
  - led[3] = a NOR b
- Latency: a clean switch change present before edge 1 appears on led at rising edge DEBOUNCE_CYCLES+3.
  - edges 1–2: synchronizer
  - edges 3..N+2: debounce
  - edge N+3: output register
- Simultaneous change of both bits: each bit is accepted independently. Skew of less than one cycle between bits may produce one intermediate led value for one cycle; this is allowed.
- Reset mid-debounce: count discarded; led goes to 0 immediately.
- No other outputs; no handshake.

Decomposition:
- Package logic_gate_panel_pkg:
  - LED index constants LED_AND=0, LED_OR=1, LED_XOR=2, LED_NOR=3
  - default DEBOUNCE_CYCLES constant
- Sub-module switch_debounce: 1-bit synchronizer plus debouncer with DEBOUNCE_CYCLES parameter, ports clk, rst_n, din, dout. Instantiated twice (generate loop).
- Gate logic and output register stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, so latency = 7 edges):
- Reset/idle: hold rst_n=0 with switch=00 → led=0000 during reset. One edge after release → led=1000.
- Truth table: apply each pattern for 20 cycles, checking led after 7 edges:
  - switch=10 (b=1, a=0) → led=0110
  - switch=01 → led=0110
  - switch=11 → led=0011
  - switch=00 → led=1000
- Latency check: 00→11 change; led stays 1000 through edge 6 and equals 0011 exactly at edge 7.
- Glitch rejection: from 00, pulse switch[0]=1 for 3 cycles → led stays 1000. A 4-cycle-or-longer pulse → led=0110 after 7 edges.
- Reset mid-operation: switch=11 settled (led=0011). Change to 00, assert rst_n=0 at edge 4 → led=0000 immediately. After release → 1000 with no transient 0011.
- Independent bits: toggle switch[1] 0→1 while switch[0] bounces every 2 cycles → led follows b only. With a held 0, led=0110.
